// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider and its stall controller.
package div_pkg;

  localparam int unsigned DIV_XLEN           = 32;
  localparam int unsigned DIV_BITS_PER_CYCLE = 4;

  // RV32M division operation encodings
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Start-to-valid distance; the stall controller derives its stall count from this.
  function automatic int unsigned div_latency(input int unsigned xlen,
                                              input int unsigned bits_per_cycle);
    return xlen / bits_per_cycle + 2;
  endfunction

endpackage

// File: rtl/div_step.sv
// One iteration of radix-2^BITS_PER_CYCLE restoring division: chained
// shift-and-trial-subtract stages, MSB of the dividend chunk first.
module div_step #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic [XLEN-1:0]           rem_in,
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [XLEN-1:0]           divisor,
  output logic [XLEN-1:0]           rem_out,
  output logic [BITS_PER_CYCLE-1:0] q_bits
);

  logic [XLEN-1:0]           rem_v;
  logic [XLEN:0]             shifted;
  logic [XLEN:0]             diff;
  logic [BITS_PER_CYCLE-1:0] chunk_v;
  logic [BITS_PER_CYCLE-1:0] q_v;

  // Chain of restoring stages; diff[XLEN] is the borrow of the trial subtraction
  always_comb begin
    rem_v   = rem_in;
    chunk_v = chunk;
    q_v     = '0;
    shifted = '0;
    diff    = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_v, chunk_v[BITS_PER_CYCLE-1]};
      chunk_v = chunk_v << 1;
      diff    = shifted - {1'b0, divisor};
      if (!diff[XLEN]) begin
        rem_v = diff[XLEN-1:0];
        q_v   = (q_v << 1) | BITS_PER_CYCLE'(1);
      end else begin
        rem_v = shifted[XLEN-1:0];
        q_v   = q_v << 1;
      end
    end
    rem_out = rem_v;
    q_bits  = q_v;
  end

endmodule

// File: rtl/iter_div_unit.sv
// Fixed-latency multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
module iter_div_unit
  import div_pkg::*;
#(
  parameter int unsigned XLEN           = DIV_XLEN,
  parameter int unsigned BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned LATENCY = div_latency(XLEN, BITS_PER_CYCLE);
  localparam int unsigned ITERS   = LATENCY - 2;
  localparam int unsigned CNT_W   = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  if ((XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_radix
    $error("iter_div_unit: XLEN must be a multiple of BITS_PER_CYCLE");
  end

  div_state_e                state_q, state_d;
  logic                      accept;
  logic [1:0]                op_q;
  logic [XLEN-1:0]           a_q, b_q;
  logic [XLEN-1:0]           rem_q, quo_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      q_neg_q, r_neg_q, dbz_q, ovf_q;
  logic                      signed_op, is_rem;
  logic [XLEN-1:0]           a_abs, b_abs;
  logic [XLEN-1:0]           step_rem;
  logic [BITS_PER_CYCLE-1:0] step_q;
  logic [XLEN-1:0]           quo_next;
  logic [XLEN-1:0]           q_fix, r_fix, result_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush beats start, and a committed DONE cannot be flushed
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = start && !flush;
        if (accept) state_d = ST_PREP;
      end
      ST_PREP: state_d = flush ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (flush)              state_d = ST_IDLE;
        else if (cnt_q == '0)   state_d = ST_DONE;
      end
      ST_DONE: begin
        accept  = start && !flush;
        state_d = accept ? ST_PREP : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operation decode and operand magnitude for the signed ops
  always_comb begin
    signed_op = 1'b0;
    is_rem    = 1'b0;
    unique case (op_q)
      DIV_OP_DIV:  begin signed_op = 1'b1; is_rem = 1'b0; end
      DIV_OP_DIVU: begin signed_op = 1'b0; is_rem = 1'b0; end
      DIV_OP_REM:  begin signed_op = 1'b1; is_rem = 1'b1; end
      DIV_OP_REMU: begin signed_op = 1'b0; is_rem = 1'b1; end
      default:     begin signed_op = 1'b0; is_rem = 1'b0; end
    endcase
    a_abs = (signed_op && a_q[XLEN-1]) ? (~a_q + XLEN'(1)) : a_q;
    b_abs = (signed_op && b_q[XLEN-1]) ? (~b_q + XLEN'(1)) : b_q;
  end

  div_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in  (rem_q),
    .chunk   (a_q[XLEN-1 -: BITS_PER_CYCLE]),
    .divisor (b_q),
    .rem_out (step_rem),
    .q_bits  (step_q)
  );

  // Final result with sign correction; REM by zero falls out of the
  // iteration as |dividend| re-signed, i.e. the dividend itself
  always_comb begin
    quo_next = (quo_q << BITS_PER_CYCLE) | XLEN'(step_q);
    q_fix    = q_neg_q ? (~quo_next + XLEN'(1)) : quo_next;
    r_fix    = r_neg_q ? (~step_rem + XLEN'(1)) : step_rem;
    if (dbz_q) q_fix = '1;
    if (ovf_q) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    result_next = is_rem ? r_fix : q_fix;
  end

  // Datapath: latch at accept, condition in PREP, iterate, register result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      result  <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= dividend;
        b_q  <= divisor;
      end
      if (state_q == ST_PREP) begin
        a_q     <= a_abs;
        b_q     <= b_abs;
        q_neg_q <= signed_op && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        r_neg_q <= signed_op && a_q[XLEN-1];
        dbz_q   <= (b_q == '0);
        ovf_q   <= signed_op && (a_q == MIN_NEG) && (b_q == '1);
        rem_q   <= '0;
        quo_q   <= '0;
        cnt_q   <= CNT_W'(ITERS - 1);
      end
      if (state_q == ST_ITER) begin
        a_q   <= a_q << BITS_PER_CYCLE;
        rem_q <= step_rem;
        quo_q <= quo_next;
        cnt_q <= cnt_q - CNT_W'(1);
        if (state_d == ST_DONE) result <= result_next;
      end
    end
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      busy  <= (state_d == ST_PREP) || (state_d == ST_ITER);
      valid <= (state_d == ST_DONE);
    end
  end

endmodule
